// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences one single-ported, variable-latency memory
// shared by instruction fetch and the data (MEM) stage. Data wins arbitration
// unless it has already taken MAX_DATA_BURST grants in a row while a fetch
// was waiting. Every transaction is followed by one idle turnaround cycle.
// A transaction that sees no ack within TIMEOUT cycles is abandoned and the
// sticky err flag is raised.
module mem_port_arbiter #(
  parameter int WORD_LEN       = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch side
  input  logic                if_req,
  input  logic [WORD_LEN-1:0] if_addr,
  output logic [WORD_LEN-1:0] if_rdata,
  output logic                if_valid,
  output logic                freeze,
  // data side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                d_done,
  output logic                d_stall,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic                err
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_DATA_BURST);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                turn_q, turn_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_LEN-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_LEN-1:0] d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_done_q, d_done_d;
  logic                err_q, err_d;

  // Next-state: arbitration in IDLE, ack/timeout handling while a request is out
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    timer_d     = timer_q;
    turn_d      = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_done_d    = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        // turn_q marks the turnaround cycle right after a transaction; the
        // finished requester is still holding req then, so no grant is made.
        if (!turn_q) begin
          if (d_req && (!if_req || (burst_q < BURST_MAX))) begin
            state_d     = DATA;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            timer_d     = '0;
            // burst_q < BURST_MAX whenever if_req is high here, so the
            // increment can never pass the saturation value.
            burst_d     = if_req ? burst_q + 1'b1 : '0;
          end else if (if_req) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            timer_d    = '0;
            burst_d    = '0;
          end else begin
            burst_d = '0;
          end
        end
      end
      FETCH, DATA: begin
        if (mem_ack) begin
          if (state_q == FETCH) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_done_d = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = IDLE;
          turn_d    = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          turn_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      timer_q     <= '0;
      turn_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      timer_q     <= timer_d;
      turn_q      <= turn_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_done    = d_done_q;
  assign err       = err_q;

  // Stalls are gated by rst so they read 0 while reset is held
  assign freeze  = rst & if_req & ~if_valid_q;
  assign d_stall = rst & d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int W    = 32;
  localparam int MAXB = 4;
  localparam int TO   = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic [W-1:0] if_rdata;
  logic         if_valid, freeze;
  logic         d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] d_addr = '0, d_wdata = '0;
  logic [W-1:0] d_rdata;
  logic         d_done, d_stall;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_LEN(W), .MAX_DATA_BURST(MAXB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .freeze(freeze),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: who owns the memory, what was latched, how long it has waited
  int           m_owner;      // 0 none, 1 fetch, 2 data
  int           m_age, m_lat, m_burst;
  bit           m_cool, m_err, m_if_valid, m_d_done, m_we;
  logic [W-1:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  int           grants[$];

  bit           rand_mode = 1'b0;
  int           dir_lat   = 1;
  logic [W-1:0] rd_val    = '0;
  bit           chk_en    = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_lat = 0; m_burst = 0;
    m_cool = 0; m_err = 0; m_if_valid = 0; m_d_done = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
  endtask

  task automatic model_grant(int kind, logic [W-1:0] a, bit we, logic [W-1:0] wd);
    m_owner = kind; m_addr = a; m_we = we; m_wdata = wd; m_age = 0;
    if (rand_mode) m_lat = ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(1, 4));
    else           m_lat = dir_lat;
    grants.push_back(kind);
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_step();
    m_if_valid = 0;
    m_d_done   = 0;
    if (m_owner != 0) begin
      if (mem_ack) begin
        if (m_owner == 1) begin
          m_if_rdata = mem_rdata; m_if_valid = 1;
          $display("[TB] fetch addr=%08h data=%08h", m_addr, mem_rdata);
        end else begin
          if (!m_we) m_d_rdata = mem_rdata;
          m_d_done = 1;
          $display("[TB] %s addr=%08h data=%08h", m_we ? "store" : "load ", m_addr,
                   m_we ? m_wdata : mem_rdata);
        end
        m_owner = 0; m_cool = 1;
      end else begin
        m_age++;
        if (m_age >= TO) begin
          m_err = 1; m_owner = 0; m_cool = 1;
          $display("[TB] timeout addr=%08h", m_addr);
        end
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else begin
      if (d_req && (!if_req || m_burst < MAXB)) begin
        model_grant(2, d_addr, d_we, d_wdata);
        m_burst = if_req ? ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1) : 0;
      end else if (if_req) begin
        model_grant(1, if_addr, 1'b0, '0);
        m_burst = 0;
      end else begin
        m_burst = 0;
      end
    end
  endtask

  // Memory emulator: acks after the latency chosen at grant; stray acks while idle
  task automatic drive_mem();
    if (m_owner != 0) mem_ack = (m_age + 1 == m_lat);
    else              mem_ack = rand_mode && ($urandom_range(0, 5) == 0);
    mem_rdata = rand_mode ? W'($urandom()) : rd_val;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    drive_mem();
  endtask

  task automatic drive_random();
    if (!if_req || m_if_valid) begin
      if_req = ($urandom_range(0, 2) == 0);
      if_addr = W'($urandom()) & ~W'(3);
    end else if ($urandom_range(0, 31) == 0) begin
      if_req = 1'b0;
    end
    if ($urandom_range(0, 3) == 0) if_addr = W'($urandom()) & ~W'(3);
    if (!d_req || m_d_done) begin
      d_req   = ($urandom_range(0, 1) == 0);
      d_we    = $urandom_range(0, 1) == 1;
      d_addr  = W'($urandom());
      d_wdata = W'($urandom());
    end else if ($urandom_range(0, 31) == 0) begin
      d_req = 1'b0;
    end
    if ($urandom_range(0, 3) == 0) begin
      d_addr = W'($urandom()); d_wdata = W'($urandom()); d_we = $urandom_range(0, 1) == 1;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", {31'b0, mem_req}, {31'b0, m_owner != 0});
      if (m_owner != 0) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, m_we});
        check("mem_addr", mem_addr, m_addr);
        if (m_owner == 2 && m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      check("if_valid", {31'b0, if_valid}, {31'b0, m_if_valid});
      check("d_done", {31'b0, d_done}, {31'b0, m_d_done});
      check("if_rdata", if_rdata, m_if_rdata);
      check("d_rdata", d_rdata, m_d_rdata);
      check("err", {31'b0, err}, {31'b0, m_err});
      check("freeze", {31'b0, freeze}, {31'b0, rst & if_req & ~m_if_valid});
      check("d_stall", {31'b0, d_stall}, {31'b0, rst & d_req & ~m_d_done});
    end
  end

  initial begin
    int exp_pat[6];
    int waited, req_cycles;
    bit saw;
    exp_pat = '{2, 2, 2, 2, 1, 2};
    model_reset();

    // Reset state, with requests raised to show the stalls stay low
    if_req = 1'b1; d_req = 1'b1;
    tick();
    chk_en = 1'b1;
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_freeze", {31'b0, freeze}, 32'd0);
    check("rst_d_stall", {31'b0, d_stall}, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Fetch alone, ack one cycle after grant
    if_addr = 32'h40; if_req = 1'b1; rd_val = 32'h8C220004; dir_lat = 1;
    #1 check("fetch_freeze_c0", {31'b0, freeze}, 32'd1);
    tick(); #1;
    check("fetch_mem_req_c1", {31'b0, mem_req}, 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h40);
    check("fetch_mem_we", {31'b0, mem_we}, 32'd0);
    check("fetch_freeze_c1", {31'b0, freeze}, 32'd1);
    tick(); #1;
    check("fetch_valid_c2", {31'b0, if_valid}, 32'd1);
    check("fetch_rdata", if_rdata, 32'h8C220004);
    check("fetch_freeze_c2", {31'b0, freeze}, 32'd0);
    if_req = 1'b0;
    tick(); #1;
    check("fetch_valid_c3", {31'b0, if_valid}, 32'd0);

    // Simultaneous requests: data first, fetch after the turnaround
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; rd_val = 32'h11112222;
    tick(); #1;
    check("simul_data_addr", mem_addr, 32'h100);
    check("simul_data_we", {31'b0, mem_we}, 32'd0);
    tick(); #1;
    check("simul_d_done", {31'b0, d_done}, 32'd1);
    check("simul_d_rdata", d_rdata, 32'h11112222);
    d_req = 1'b0;
    tick(); #1;
    check("simul_turnaround", {31'b0, mem_req}, 32'd0);
    tick(); #1;
    check("simul_fetch_req", {31'b0, mem_req}, 32'd1);
    check("simul_fetch_addr", mem_addr, 32'h44);
    tick(); #1;
    check("simul_fetch_valid", {31'b0, if_valid}, 32'd1);
    if_req = 1'b0;
    repeat (3) tick();

    // Starvation guard: both held, immediate acks
    grants.delete();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; if_addr = 32'h48;
    repeat (30) tick();
    check("starve_ngrants", {31'b0, grants.size() >= 6}, 32'd1);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check($sformatf("starve_grant%0d", i), grants[i], exp_pat[i]);
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    // Store: latched values on the bus, d_rdata keeps the last load value
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    rd_val = 32'h55555555; dir_lat = 2;
    tick(); #1;
    check("store_mem_we", {31'b0, mem_we}, 32'd1);
    check("store_mem_addr", mem_addr, 32'h20);
    check("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    d_addr = 32'h999; d_wdata = 32'h0;
    tick(); #1;
    check("store_addr_held", mem_addr, 32'h20);
    tick(); #1;
    check("store_d_done", {31'b0, d_done}, 32'd1);
    check("store_d_rdata_kept", d_rdata, 32'h11112222);
    d_req = 1'b0;
    repeat (3) tick();

    // Timeout: no ack for a fetch, then a normal fetch still works
    if_req = 1'b1; if_addr = 32'h80; dir_lat = 1000;
    #1;
    waited = 0;
    while (mem_req !== 1'b1 && waited < 10) begin tick(); #1; waited++; end
    check("to_granted", {31'b0, mem_req}, 32'd1);
    req_cycles = 0; saw = 0;
    while (mem_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      if (if_valid) saw = 1;
      tick(); #1;
    end
    check("to_req_cycles", req_cycles, 32'd16);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_no_valid", {31'b0, saw}, 32'd0);
    dir_lat = 1; rd_val = 32'hCAFEF00D;
    waited = 0;
    while (if_valid !== 1'b1 && waited < 10) begin tick(); #1; waited++; end
    check("to_refetch_valid", {31'b0, if_valid}, 32'd1);
    check("to_refetch_rdata", if_rdata, 32'hCAFEF00D);
    check("to_err_sticky", {31'b0, err}, 32'd1);
    if_req = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a data transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; dir_lat = 1000;
    tick(); #1;
    check("rstmid_req_before", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_req_drop", {31'b0, mem_req}, 32'd0);
    check("rstmid_err", {31'b0, err}, 32'd0);
    check("rstmid_d_stall", {31'b0, d_stall}, 32'd0);
    model_reset();
    d_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    saw = 0;
    repeat (5) begin tick(); #1; if (d_done) saw = 1; end
    check("rstmid_no_done", {31'b0, saw}, 32'd0);

    // Randomized traffic against the model
    rand_mode = 1'b1;
    repeat (2500) begin
      tick();
      drive_random();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (50) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
